// File: rtl/seg_scan_controller.sv
// seg_scan_controller
//   Time-multiplexes NUM_DIGITS hex digits onto one shared segment bus.
//   A prescaler divides each digit slot into DIV_COUNT+1 clocks. The first
//   BLANK_CYCLES clocks of a slot keep every anode dark to stop ghosting.
//   Inputs are sampled into shadow registers once per frame, and at
//   start-up, so that a frame never mixes old and new data.
//
// Ports
//   clock_in     system clock
//   reset        asynchronous, active-high
//   enable       scan enable; low puts the display dark and idles the FSM
//   digit_data   4*NUM_DIGITS hex nibbles, digit 0 in [3:0]
//   dp_in        decimal point per digit
//   digit_en     per-digit anode enable mask
//   lz_suppress  blank leading zeros (digit 0 is never blanked)
//   anode_out    one-hot digit drive in the active polarity
//   seg_out      segments a..g on bits 0..6
//   dp_out       decimal point
//   digit_sel    index of the current slot
//   scan_tick    one-cycle pulse after each frame wrap
//
// Every output is registered. Each output is computed from next-state
// values, so it lines up with the state register on the same edge.
module seg_scan_controller #(
   parameter int NUM_DIGITS   = 4,
   parameter int DIV_COUNT    = 499,
   parameter int BLANK_CYCLES = 16,
   parameter bit ACTIVE_LOW   = 1'b1,
   localparam int SEL_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clock_in,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [4*NUM_DIGITS-1:0] digit_data,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    lz_suppress,
   output logic [NUM_DIGITS-1:0]   anode_out,
   output logic [6:0]              seg_out,
   output logic                    dp_out,
   output logic [SEL_W-1:0]        digit_sel,
   output logic                    scan_tick
);

   localparam int P_W = (DIV_COUNT > 0) ? $clog2(DIV_COUNT + 1) : 1;
   localparam logic [P_W-1:0]   DIV_LAST   = P_W'(DIV_COUNT);
   localparam logic [P_W-1:0]   BLANK_LAST = P_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

   state_t                  state, state_nx;
   logic [P_W-1:0]          p, p_nx;
   logic [SEL_W-1:0]        sel_nx;
   logic [4*NUM_DIGITS-1:0] sh_data, sh_data_nx;
   logic [NUM_DIGITS-1:0]   sh_dp, sh_dp_nx;
   logic [NUM_DIGITS-1:0]   sh_en, sh_en_nx;
   logic                    sh_lz, sh_lz_nx;
   logic                    load, wrap;
   logic [NUM_DIGITS-1:0]   lz_zero;
   logic                    run;
   logic [NUM_DIGITS-1:0]   anode_hi;
   logic [6:0]              seg_hi;
   logic                    dp_hi;
   logic [3:0]              nib;

   // Active-high hex to seven-segment, bit0 = a.
   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
      endcase
   endfunction

   // The FSM state and the prescaler.
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         p     <= '0;
      end else begin
         state <= state_nx;
         p     <= p_nx;
      end
   end

   // Next-state logic. Dropping enable always wins and sends the FSM to IDLE.
   // With BLANK_CYCLES=0 every slot goes straight to DRIVE.
   always_comb begin
      state_nx = state;
      p_nx     = p;
      sel_nx   = digit_sel;
      load     = 1'b0;
      wrap     = 1'b0;
      if (!enable) begin
         state_nx = IDLE;
         p_nx     = '0;
      end else begin
         case (state)
            IDLE: begin
               // Resume at the held digit. This is a restart, not a frame wrap.
               state_nx = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
               p_nx     = '0;
               load     = 1'b1;
            end
            BLANK: begin
               p_nx = p + 1'b1;
               if (p == BLANK_LAST) state_nx = DRIVE;
            end
            DRIVE: begin
               if (p == DIV_LAST) begin
                  p_nx     = '0;
                  state_nx = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
                  if (digit_sel == SEL_LAST) begin
                     sel_nx = '0;
                     wrap   = 1'b1;
                     load   = 1'b1;
                  end else begin
                     sel_nx = digit_sel + 1'b1;
                  end
               end else begin
                  p_nx = p + 1'b1;
               end
            end
            default: begin
               state_nx = IDLE;
               p_nx     = '0;
            end
         endcase
      end
   end

   assign sh_data_nx = load ? digit_data  : sh_data;
   assign sh_dp_nx   = load ? dp_in       : sh_dp;
   assign sh_en_nx   = load ? digit_en    : sh_en;
   assign sh_lz_nx   = load ? lz_suppress : sh_lz;

   // lz_zero[i] is set when digit i and every higher digit are zero.
   // Digit 0 is excluded so that an all-zero value still shows a single "0".
   always_comb begin
      run     = 1'b1;
      lz_zero = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         run        = run && (sh_data_nx[4*i +: 4] == 4'h0);
         lz_zero[i] = run && (i != 0);
      end
   end

   // Output values in active-high form. The polarity is applied at the register.
   always_comb begin
      nib      = sh_data_nx[{sel_nx, 2'b00} +: 4];
      anode_hi = '0;
      seg_hi   = '0;
      dp_hi    = 1'b0;
      if (state_nx == DRIVE) begin
         if (sh_en_nx[sel_nx]) anode_hi = NUM_DIGITS'(1) << sel_nx;
         if (!(sh_lz_nx && lz_zero[sel_nx])) seg_hi = hex7(nib);
         dp_hi = sh_dp_nx[sel_nx];
      end
   end

   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         sh_data   <= '0;
         sh_dp     <= '0;
         sh_en     <= '0;
         sh_lz     <= 1'b0;
         digit_sel <= '0;
         scan_tick <= 1'b0;
         anode_out <= {NUM_DIGITS{ACTIVE_LOW}};
         seg_out   <= {7{ACTIVE_LOW}};
         dp_out    <= ACTIVE_LOW;
      end else begin
         sh_data   <= sh_data_nx;
         sh_dp     <= sh_dp_nx;
         sh_en     <= sh_en_nx;
         sh_lz     <= sh_lz_nx;
         digit_sel <= sel_nx;
         scan_tick <= wrap;
         anode_out <= ACTIVE_LOW ? ~anode_hi : anode_hi;
         seg_out   <= ACTIVE_LOW ? ~seg_hi   : seg_hi;
         dp_out    <= ACTIVE_LOW ? ~dp_hi    : dp_hi;
      end
   end

endmodule
